// File: rtl/pll_mdrp_pkg.sv
// Shared encodings for the PLL MDRP master: port opcodes, FSM states, default address width.
package pll_mdrp_pkg;

  localparam int unsigned DEF_ADDR_W = 7;

  typedef enum logic [1:0] {
    MDOPC_NOP   = 2'b00,
    MDOPC_WRITE = 2'b01,
    MDOPC_READ  = 2'b10,
    MDOPC_ARST  = 2'b11
  } mdopc_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_INC,
    ST_OP,
    ST_CAP,
    ST_VFY,
    ST_RSP
  } state_t;

endpackage

// File: rtl/pll_mdrp_if.sv
// Request/response handshake between control logic (master) and pll_mdrp_master (slave).
interface pll_mdrp_if #(
  parameter int unsigned ADDR_W = pll_mdrp_pkg::DEF_ADDR_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              rsp_valid;
  logic [7:0]        rsp_rdata;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/pll_mdrp_slot_timer.sv
// Slot counter: mdclk low for the first HALF cycles of a slot, high for the rest; start/last strobes.
module pll_mdrp_slot_timer #(
  parameter int unsigned HALF = 1
) (
  input  logic clkin,
  input  logic reset,
  input  logic run,
  output logic mdclk,
  output logic slot_start,
  output logic slot_last
);
  localparam int unsigned LAST = 2 * HALF - 1;

  logic [4:0] cnt;
  logic [4:0] cnt_n;

  // Counter parks at zero while idle so the first slot starts the cycle after acceptance.
  always_comb begin
    cnt_n = '0;
    if (run && cnt != 5'(LAST)) cnt_n = cnt + 5'd1;
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      cnt   <= '0;
      mdclk <= 1'b0;
    end else begin
      cnt   <= cnt_n;
      mdclk <= (cnt_n >= 5'(HALF));
    end
  end

  assign slot_start = run && (cnt == '0);
  assign slot_last  = run && (cnt == 5'(LAST));

endmodule

// File: rtl/pll_mdrp_master.sv
// Fabric-side initiator for the PLL dynamic reconfiguration port with a shadow address pointer.
// Optional write readback verification: define PLL_MDRP_VERIFY_EN.
module pll_mdrp_master
  import pll_mdrp_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned MDCLK_HALF = 1
) (
  input  logic       clkin,
  input  logic       reset,
  pll_mdrp_if.slave  req_if,
  output logic       mdclk,
  output logic [1:0] mdopc,
  output logic       mdainc,
  output logic [7:0] mdwdi,
  input  logic [7:0] mdrdo
);
  state_t            state, nxt;
  logic [ADDR_W-1:0] addr_q, ptr, ptr_inc;
  logic [7:0]        wdata_q, wdata_n, rdata_q;
  logic              we_q, we_n, ptr_valid, vfy_ph_n;
  logic              req_ready_q, busy_q, rsp_valid_q;
  logic              run, accept, slot_start, slot_last;
`ifdef PLL_MDRP_VERIFY_EN
  logic              vfy_ph, rsp_err_q;
`endif

  function automatic state_t seek(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] p,
                                  input logic pv);
    state_t s;
    if (!pv || a < p) s = ST_RST;
    else if (a > p)   s = ST_INC;
    else              s = ST_OP;
    return s;
  endfunction

  function automatic mdopc_t slot_opc(input state_t s, input logic we, input logic vph);
    mdopc_t o;
    case (s)
      ST_RST:  o = MDOPC_ARST;
      ST_OP:   o = we ? MDOPC_WRITE : MDOPC_READ;
      ST_VFY:  o = vph ? MDOPC_NOP : MDOPC_READ;
      default: o = MDOPC_NOP;
    endcase
    return o;
  endfunction

  assign run     = state inside {ST_RST, ST_INC, ST_OP, ST_CAP, ST_VFY};
  assign accept  = req_ready_q && req_if.req_valid;
  assign ptr_inc = ptr + ADDR_W'(1);

  pll_mdrp_slot_timer #(.HALF(MDCLK_HALF)) u_timer (
    .clkin      (clkin),
    .reset      (reset),
    .run        (run),
    .mdclk      (mdclk),
    .slot_start (slot_start),
    .slot_last  (slot_last)
  );

  // Next state is evaluated at acceptance and at every slot boundary; the slot
  // outputs for that next state are registered on the same edge.
  always_comb begin
    nxt      = ST_IDLE;
    vfy_ph_n = 1'b0;
    we_n     = we_q;
    wdata_n  = wdata_q;
    case (state)
      ST_IDLE: begin
        nxt     = seek(req_if.req_addr, ptr, ptr_valid);
        we_n    = req_if.req_we;
        wdata_n = req_if.req_wdata;
      end
      ST_RST: nxt = (addr_q == '0) ? ST_OP : ST_INC;
      ST_INC: nxt = (ptr_inc == addr_q) ? ST_OP : ST_INC;
`ifdef PLL_MDRP_VERIFY_EN
      ST_OP:  nxt = we_q ? ST_VFY : ST_CAP;
      ST_VFY: begin
        nxt      = vfy_ph ? ST_RSP : ST_VFY;
        vfy_ph_n = !vfy_ph;
      end
`else
      ST_OP:  nxt = we_q ? ST_RSP : ST_CAP;
`endif
      ST_CAP: nxt = ST_RSP;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      ptr_valid   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      mdopc       <= MDOPC_NOP;
      mdainc      <= 1'b0;
      mdwdi       <= '0;
`ifdef PLL_MDRP_VERIFY_EN
      vfy_ph      <= 1'b0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        addr_q      <= req_if.req_addr;
        wdata_q     <= req_if.req_wdata;
        we_q        <= req_if.req_we;
        req_ready_q <= 1'b0;
        busy_q      <= 1'b1;
      end
      if (accept || slot_last) begin
        state       <= nxt;
        mdopc       <= slot_opc(nxt, we_n, vfy_ph_n);
        mdainc      <= (nxt == ST_INC);
        rsp_valid_q <= (nxt == ST_RSP);
        if (nxt == ST_OP && we_n) mdwdi <= wdata_n;
      end
      if (slot_last && state == ST_RST) begin
        ptr       <= '0;
        ptr_valid <= 1'b1;
      end
      if (slot_last && state == ST_INC) ptr <= ptr_inc;
      if (slot_last && state == ST_CAP) begin
        rdata_q <= mdrdo;
`ifdef PLL_MDRP_VERIFY_EN
        rsp_err_q <= 1'b0;
`endif
      end
`ifdef PLL_MDRP_VERIFY_EN
      if (slot_last && state == ST_VFY) begin
        vfy_ph <= vfy_ph_n;
        if (vfy_ph) begin
          rdata_q   <= mdrdo;
          rsp_err_q <= (mdrdo != wdata_q);
        end
      end
`endif
      if (state == ST_RSP) begin
        state       <= ST_IDLE;
        rsp_valid_q <= 1'b0;
        busy_q      <= 1'b0;
        req_ready_q <= 1'b1;
      end
    end
  end

  assign req_if.req_ready = req_ready_q;
  assign req_if.busy      = busy_q;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_rdata = rdata_q;
`ifdef PLL_MDRP_VERIFY_EN
  assign req_if.rsp_err   = rsp_err_q;
`else
  assign req_if.rsp_err   = 1'b0;
`endif

  // Slots always open with mdclk low.
  slot_start_low: assert property (@(posedge clkin) disable iff (reset) slot_start |-> !mdclk);

endmodule

// File: tb/tb_pll_mdrp_master.sv
// Directed bench for pll_mdrp_master with a behavioural PLL port model (MDCLK_HALF = 1 and 3).
`timescale 1ns/1ps
module tb_pll_mdrp_master;
`ifdef PLL_MDRP_VERIFY_EN
  localparam int VS = 2;
`else
  localparam int VS = 0;
`endif

  logic clkin = 1'b0;
  logic reset = 1'b1;
  always #10 clkin = ~clkin;

  int errors = 0;
  int checks = 0;

  pll_mdrp_if #(.ADDR_W(7)) bus1 ();
  pll_mdrp_if #(.ADDR_W(7)) bus3 ();

  logic       mdclk1, mdainc1, mdclk3, mdainc3;
  logic [1:0] mdopc1, mdopc3;
  logic [7:0] mdwdi1, mdwdi3;
  logic [7:0] mdrdo1 = 8'h00;
  logic [7:0] mdrdo3;
  assign mdrdo3 = 8'h00;

  pll_mdrp_master #(.ADDR_W(7), .MDCLK_HALF(1)) dut1 (
    .clkin(clkin), .reset(reset), .req_if(bus1),
    .mdclk(mdclk1), .mdopc(mdopc1), .mdainc(mdainc1), .mdwdi(mdwdi1), .mdrdo(mdrdo1)
  );

  pll_mdrp_master #(.ADDR_W(7), .MDCLK_HALF(3)) dut3 (
    .clkin(clkin), .reset(reset), .req_if(bus3),
    .mdclk(mdclk3), .mdopc(mdopc3), .mdainc(mdainc3), .mdwdi(mdwdi3), .mdrdo(mdrdo3)
  );

  // PLL port model: unwritten registers read as addr ^ 0xA7; optional corruption of addr 1.
  logic [7:0]   m_reg [128];
  logic [127:0] m_wv = '0;
  logic [6:0]   m_ptr = '0;
  logic         corrupt = 1'b0;
  int n_arst = 0, n_inc = 0, n_wr = 0, n_rd = 0;

  always @(posedge mdclk1) begin
    case (mdopc1)
      2'b11: begin
        m_ptr  <= '0;
        n_arst <= n_arst + 1;
      end
      2'b01: begin
        m_reg[m_ptr] <= (corrupt && m_ptr == 7'd1) ? (mdwdi1 ^ 8'h01) : mdwdi1;
        m_wv[m_ptr]  <= 1'b1;
        n_wr         <= n_wr + 1;
      end
      2'b10: begin
        mdrdo1 <= m_wv[m_ptr] ? m_reg[m_ptr] : (8'hA7 ^ {1'b0, m_ptr});
        n_rd   <= n_rd + 1;
      end
      default: ;
    endcase
    if (mdainc1) begin
      m_ptr <= m_ptr + 7'd1;
      n_inc <= n_inc + 1;
    end
  end

  // Issues one request on bus1; lat is the cycle of rsp_valid after acceptance (-1 on timeout).
  task automatic issue1(input logic we, input logic [6:0] a, input logic [7:0] d,
                        output int lat, output logic [1:0] opc_first);
    int w = 0;
    lat = -1;
    @(negedge clkin);
    while (bus1.req_ready !== 1'b1 && w < 100) begin
      @(negedge clkin);
      w++;
    end
    bus1.req_valid = 1'b1;
    bus1.req_we    = we;
    bus1.req_addr  = a;
    bus1.req_wdata = d;
    @(negedge clkin);
    bus1.req_valid = 1'b0;
    bus1.req_we    = ~we;
    bus1.req_addr  = 7'h7F;
    bus1.req_wdata = 8'hEE;
    opc_first = mdopc1;
    for (int c = 1; c < 200; c++) begin
      if (bus1.rsp_valid === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge clkin);
    end
  endtask

  task automatic test_reset();
    if ({bus1.req_ready, bus1.busy, bus1.rsp_valid, bus1.rsp_err} !== 4'b1000) begin
      $display("FAIL reset_handshake: got %b expected 1000",
               {bus1.req_ready, bus1.busy, bus1.rsp_valid, bus1.rsp_err});
      errors++;
    end
    checks++;
    if (bus1.rsp_rdata !== 8'h00) begin
      $display("FAIL reset_rdata: got %h expected 00", bus1.rsp_rdata);
      errors++;
    end
    checks++;
    if ({mdclk1, mdopc1, mdainc1, mdwdi1} !== 12'h000) begin
      $display("FAIL reset_port: got mdclk=%b mdopc=%b mdainc=%b mdwdi=%h expected all zero",
               mdclk1, mdopc1, mdainc1, mdwdi1);
      errors++;
    end
    checks++;
    if ({bus3.req_ready, bus3.busy, mdclk3, mdopc3, mdainc3} !== 6'b100000) begin
      $display("FAIL reset_dut3: got %b expected 100000",
               {bus3.req_ready, bus3.busy, mdclk3, mdopc3, mdainc3});
      errors++;
    end
    checks++;
  endtask

  task automatic test_write_addr0();
    int lat, a0, w0, i0;
    logic [1:0] opc;
    a0 = n_arst; w0 = n_wr; i0 = n_inc;
    issue1(1'b1, 7'd0, 8'h10, lat, opc);
    if (lat !== 1 + 2 * (2 + VS)) begin
      $display("FAIL wr0_latency: got %0d expected %0d", lat, 1 + 2 * (2 + VS));
      errors++;
    end
    checks++;
    if (opc !== 2'b11) begin
      $display("FAIL wr0_first_slot: got %b expected 11", opc);
      errors++;
    end
    checks++;
    if (n_arst - a0 != 1 || n_wr - w0 != 1 || n_inc - i0 != 0) begin
      $display("FAIL wr0_slots: got arst=%0d wr=%0d inc=%0d expected 1 1 0",
               n_arst - a0, n_wr - w0, n_inc - i0);
      errors++;
    end
    checks++;
    if (m_reg[0] !== 8'h10) begin
      $display("FAIL wr0_model_reg: got %h expected 10", m_reg[0]);
      errors++;
    end
    checks++;
    if (bus1.rsp_rdata !== (VS != 0 ? 8'h10 : 8'h00) || bus1.rsp_err !== 1'b0) begin
      $display("FAIL wr0_rsp: got rdata=%h err=%b expected rdata=%h err=0",
               bus1.rsp_rdata, bus1.rsp_err, (VS != 0 ? 8'h10 : 8'h00));
      errors++;
    end
    checks++;
  endtask

  task automatic test_write_inc();
    int lat, a0, i0;
    logic [1:0] opc;
    a0 = n_arst; i0 = n_inc;
    issue1(1'b1, 7'd5, 8'h33, lat, opc);
    if (lat !== 1 + 2 * (6 + VS)) begin
      $display("FAIL wr5_latency: got %0d expected %0d", lat, 1 + 2 * (6 + VS));
      errors++;
    end
    checks++;
    if (n_inc - i0 != 5 || n_arst - a0 != 0 || opc !== 2'b00) begin
      $display("FAIL wr5_slots: got inc=%0d arst=%0d first_opc=%b expected 5 0 00",
               n_inc - i0, n_arst - a0, opc);
      errors++;
    end
    checks++;
    if (m_reg[5] !== 8'h33) begin
      $display("FAIL wr5_model_reg: got %h expected 33", m_reg[5]);
      errors++;
    end
    checks++;
    if (bus1.rsp_rdata !== (VS != 0 ? 8'h33 : 8'h00)) begin
      $display("FAIL wr5_rdata: got %h expected %h", bus1.rsp_rdata, (VS != 0 ? 8'h33 : 8'h00));
      errors++;
    end
    checks++;
  endtask

  task automatic test_read();
    int lat, a0, i0, r0, w0;
    logic [1:0] opc;
    a0 = n_arst; i0 = n_inc; r0 = n_rd; w0 = n_wr;
    issue1(1'b0, 7'd2, 8'h77, lat, opc);
    if (lat !== 11) begin
      $display("FAIL rd2_latency: got %0d expected 11", lat);
      errors++;
    end
    checks++;
    if (n_arst - a0 != 1 || n_inc - i0 != 2 || n_rd - r0 != 1 || n_wr - w0 != 0) begin
      $display("FAIL rd2_slots: got arst=%0d inc=%0d rd=%0d wr=%0d expected 1 2 1 0",
               n_arst - a0, n_inc - i0, n_rd - r0, n_wr - w0);
      errors++;
    end
    checks++;
    if (bus1.rsp_rdata !== 8'hA5 || bus1.rsp_err !== 1'b0) begin
      $display("FAIL rd2_rsp: got rdata=%h err=%b expected A5 0", bus1.rsp_rdata, bus1.rsp_err);
      errors++;
    end
    checks++;
    @(negedge clkin);
    if ({bus1.rsp_valid, bus1.req_ready, bus1.busy} !== 3'b010 || bus1.rsp_rdata !== 8'hA5) begin
      $display("FAIL rd2_after: got valid/ready/busy=%b rdata=%h expected 010 A5",
               {bus1.rsp_valid, bus1.req_ready, bus1.busy}, bus1.rsp_rdata);
      errors++;
    end
    checks++;
  endtask

`ifdef PLL_MDRP_VERIFY_EN
  task automatic test_verify();
    int lat;
    logic [1:0] opc;
    corrupt = 1'b1;
    issue1(1'b1, 7'd1, 8'h08, lat, opc);
    if (lat !== 11 || bus1.rsp_err !== 1'b1 || bus1.rsp_rdata !== 8'h09) begin
      $display("FAIL vfy_bad: got lat=%0d err=%b rdata=%h expected 11 1 09",
               lat, bus1.rsp_err, bus1.rsp_rdata);
      errors++;
    end
    checks++;
    corrupt = 1'b0;
    issue1(1'b1, 7'd3, 8'h5C, lat, opc);
    if (lat !== 11 || bus1.rsp_err !== 1'b0 || bus1.rsp_rdata !== 8'h5C) begin
      $display("FAIL vfy_good: got lat=%0d err=%b rdata=%h expected 11 0 5C",
               lat, bus1.rsp_err, bus1.rsp_rdata);
      errors++;
    end
    checks++;
  endtask
`endif

  task automatic test_mdclk_half3();
    logic [6:0] a;
    logic [7:0] d;
    logic [9:0] opcs;
    logic [4:0] incm;
    logic [1:0] e_opc;
    logic       e_clk, e_inc;
    int ns, lat_exp, k;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) begin
        a = 7'd0; d = 8'h21; opcs = 10'b00_00_10_01_11; incm = 5'b00000; ns = 2 + VS;
      end else begin
        a = 7'd2; d = 8'h42; opcs = 10'b00_10_01_00_00; incm = 5'b00011; ns = 3 + VS;
      end
      lat_exp = 1 + ns * 6;
      @(negedge clkin);
      bus3.req_valid = 1'b1;
      bus3.req_we    = 1'b1;
      bus3.req_addr  = a;
      bus3.req_wdata = d;
      for (int c = 1; c <= lat_exp; c++) begin
        @(negedge clkin);
        bus3.req_valid = 1'b0;
        if (c < lat_exp) begin
          k     = (c - 1) / 6;
          e_opc = opcs[2*k +: 2];
          e_inc = incm[k];
          e_clk = (((c - 1) % 6) >= 3);
          if ({mdclk3, mdopc3, mdainc3, bus3.rsp_valid} !== {e_clk, e_opc, e_inc, 1'b0}) begin
            $display("FAIL h3_trace t=%0d c=%0d: got clk=%b opc=%b inc=%b vld=%b expected %b %b %b 0",
                     t, c, mdclk3, mdopc3, mdainc3, bus3.rsp_valid, e_clk, e_opc, e_inc);
            errors++;
          end
          checks++;
          if (e_opc == 2'b01 && mdwdi3 !== d) begin
            $display("FAIL h3_wdata t=%0d c=%0d: got %h expected %h", t, c, mdwdi3, d);
            errors++;
          end
        end else begin
          if ({bus3.rsp_valid, mdopc3, mdainc3, mdclk3} !== 5'b10000) begin
            $display("FAIL h3_rsp t=%0d: got vld=%b opc=%b inc=%b clk=%b expected 1 00 0 0",
                     t, bus3.rsp_valid, mdopc3, mdainc3, mdclk3);
            errors++;
          end
          checks++;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, a0, i0, seen;
    logic [1:0] opc;
    @(negedge clkin);
    bus1.req_valid = 1'b1;
    bus1.req_we    = 1'b1;
    bus1.req_addr  = 7'd6;
    bus1.req_wdata = 8'h66;
    @(negedge clkin);
    bus1.req_valid = 1'b0;
    @(negedge clkin);
    @(negedge clkin);
    if ({bus1.busy, mdainc1, mdopc1} !== 4'b1100) begin
      $display("FAIL rst_mid_inc: got busy=%b mdainc=%b mdopc=%b expected 1 1 00",
               bus1.busy, mdainc1, mdopc1);
      errors++;
    end
    checks++;
    reset = 1'b1;
    @(negedge clkin);
    reset = 1'b0;
    test_reset();
    seen = 0;
    repeat (30) begin
      @(negedge clkin);
      if (bus1.rsp_valid === 1'b1) seen++;
    end
    if (seen != 0) begin
      $display("FAIL rst_mid_no_rsp: got %0d rsp_valid cycles expected 0", seen);
      errors++;
    end
    checks++;
    a0 = n_arst; i0 = n_inc;
    issue1(1'b1, 7'd6, 8'h66, lat, opc);
    if (opc !== 2'b11 || lat !== 1 + 2 * (8 + VS)) begin
      $display("FAIL rst_mid_retry: got first_opc=%b lat=%0d expected 11 %0d",
               opc, lat, 1 + 2 * (8 + VS));
      errors++;
    end
    checks++;
    if (n_arst - a0 != 1 || n_inc - i0 != 6 || m_reg[6] !== 8'h66) begin
      $display("FAIL rst_mid_model: got arst=%0d inc=%0d reg6=%h expected 1 6 66",
               n_arst - a0, n_inc - i0, m_reg[6]);
      errors++;
    end
    checks++;
  endtask

  initial begin
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_addr = '0; bus3.req_wdata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clkin);
    reset = 1'b0;
    @(negedge clkin);
    test_reset();
    test_write_addr0();
    test_write_inc();
    test_read();
`ifdef PLL_MDRP_VERIFY_EN
    test_verify();
`endif
    test_mdclk_half3();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
